date_calendar_counter: RTL and testbench

//  Registered calendar engine. Holds the current date (year/month/day) and
//  day-of-year, and advances one day per tick with month/year roll-over and

---
 rtl/date_calendar_counter.sv | 142 ++++++++++++++
 tb/tb_date_calendar_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/date_calendar_counter.sv
// rtl/date_calendar_counter.sv - registered calendar date engine with tick advance and validated load
module date_calendar_counter #(
  parameter int YEAR_W     = 12,
  parameter int LEAP_MODE  = 2,
  parameter int START_YEAR = 2023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              load_valid,
  input  logic [YEAR_W-1:0] load_year,
  input  logic [3:0]        load_month,
  input  logic [4:0]        load_day,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [8:0]        doy,
  output logic [4:0]        dim,
  output logic              is_leap,
  output logic              month_wrap,
  output logic              year_wrap,
  output logic              load_err
);

  // Leap rule selected at elaboration; unused modulo terms drop out for modes 0/1.
  function automatic logic leap_of(input logic [YEAR_W-1:0] y);
    logic [31:0] yy;
    yy = 32'(y);
    case (LEAP_MODE)
      0:       return 1'b0;
      1:       return (yy % 32'd4) == 32'd0;
      default: return ((yy % 32'd4) == 32'd0) &&
                      (((yy % 32'd100) != 32'd0) || ((yy % 32'd400) == 32'd0));
    endcase
  endfunction

  // Month length; out-of-range months fall to 31 and are screened separately on load.
  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                       return lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:    return 5'd30;
      default:                    return 5'd31;
    endcase
  endfunction

  // Days before the first of month m in a common year.
  function automatic logic [8:0] cum_days(input logic [3:0] m);
    case (m)
      4'd2:    return 9'd31;
      4'd3:    return 9'd59;
      4'd4:    return 9'd90;
      4'd5:    return 9'd120;
      4'd6:    return 9'd151;
      4'd7:    return 9'd181;
      4'd8:    return 9'd212;
      4'd9:    return 9'd243;
      4'd10:   return 9'd273;
      4'd11:   return 9'd304;
      4'd12:   return 9'd334;
      default: return 9'd0;
    endcase
  endfunction

  logic [YEAR_W-1:0] n_year;
  logic [3:0]        n_month;
  logic [4:0]        n_day;
  logic [8:0]        n_doy;
  logic              n_mw, n_yw, n_err;
  logic              ld_leap, ld_ok;
  logic [4:0]        ld_dim;

  // Calendar facts of the current (registered) date.
  always_comb begin
    is_leap = leap_of(year);
    dim     = dim_of(month, is_leap);
  end

  // Next-state: load (accepted or rejected) takes priority and swallows any tick.
  always_comb begin
    n_year  = year;
    n_month = month;
    n_day   = day;
    n_doy   = doy;
    n_mw    = 1'b0;
    n_yw    = 1'b0;
    n_err   = 1'b0;
    ld_leap = leap_of(load_year);
    ld_dim  = dim_of(load_month, ld_leap);
    ld_ok   = (load_month >= 4'd1) && (load_month <= 4'd12) &&
              (load_day != 5'd0) && (load_day <= ld_dim);
    if (load_valid) begin
      if (ld_ok) begin
        n_year  = load_year;
        n_month = load_month;
        n_day   = load_day;
        n_doy   = cum_days(load_month) + {4'd0, load_day} +
                  {8'd0, (ld_leap && (load_month > 4'd2))};
      end else begin
        n_err = 1'b1;
      end
    end else if (tick) begin
      if (day < dim) begin
        n_day = day + 5'd1;
        n_doy = doy + 9'd1;
      end else if (month < 4'd12) begin
        n_day   = 5'd1;
        n_month = month + 4'd1;
        n_doy   = doy + 9'd1;
        n_mw    = 1'b1;
      end else begin
        n_day   = 5'd1;
        n_month = 4'd1;
        n_doy   = 9'd1;
        n_year  = year + 1'b1;
        n_mw    = 1'b1;
        n_yw    = 1'b1;
      end
    end
  end

  // State and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      year       <= YEAR_W'(START_YEAR);
      month      <= 4'd1;
      day        <= 5'd1;
      doy        <= 9'd1;
      month_wrap <= 1'b0;
      year_wrap  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      year       <= n_year;
      month      <= n_month;
      day        <= n_day;
      doy        <= n_doy;
      month_wrap <= n_mw;
      year_wrap  <= n_yw;
      load_err   <= n_err;
    end
  end

endmodule

// File: tb/tb_date_calendar_counter.sv
// tb/tb_date_calendar_counter.sv - self-checking bench for date_calendar_counter
module tb_date_calendar_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        load_valid = 1'b0;
  logic [11:0] load_year = '0;
  logic [3:0]  load_month = '0;
  logic [4:0]  load_day = '0;

  logic [11:0] year, y1, y0;
  logic [3:0]  month, m1, m0;
  logic [4:0]  day, d1, d0, dim, dim1, dim0;
  logic [8:0]  doy, doy1, doy0;
  logic        is_leap, lp1, lp0;
  logic        month_wrap, year_wrap, load_err, mw1, yw1, le1, mw0, yw0, le0;

  int n_chk = 0;
  int n_fail = 0;

  int my, mm, md;
  bit emw, eyw, ele;

  always #5 clk = ~clk;

  date_calendar_counter #(.YEAR_W(12), .LEAP_MODE(2), .START_YEAR(2023)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load_valid(load_valid),
    .load_year(load_year), .load_month(load_month), .load_day(load_day),
    .year(year), .month(month), .day(day), .doy(doy), .dim(dim), .is_leap(is_leap),
    .month_wrap(month_wrap), .year_wrap(year_wrap), .load_err(load_err));

  date_calendar_counter #(.YEAR_W(12), .LEAP_MODE(1), .START_YEAR(2023)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load_valid(load_valid),
    .load_year(load_year), .load_month(load_month), .load_day(load_day),
    .year(y1), .month(m1), .day(d1), .doy(doy1), .dim(dim1), .is_leap(lp1),
    .month_wrap(mw1), .year_wrap(yw1), .load_err(le1));

  date_calendar_counter #(.YEAR_W(12), .LEAP_MODE(0), .START_YEAR(2023)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load_valid(load_valid),
    .load_year(load_year), .load_month(load_month), .load_day(load_day),
    .year(y0), .month(m0), .day(d0), .doy(doy0), .dim(dim0), .is_leap(lp0),
    .month_wrap(mw0), .year_wrap(yw0), .load_err(le0));

  function automatic int m_leap(input int y);
    return ((y % 4) == 0 && (y % 100) != 0) || ((y % 400) == 0);
  endfunction

  function automatic int m_dim(input int m, input int y);
    if (m == 2) return m_leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int m_doy(input int m, input int d, input int y);
    int s;
    s = d;
    for (int k = 1; k < m; k++) s += m_dim(k, y);
    return s;
  endfunction

  function automatic logic [43:0] exp_vec();
    return {12'(my), 4'(mm), 5'(md), 9'(m_doy(mm, md, my)), 5'(m_dim(mm, my)),
            1'(m_leap(my)), emw, eyw, ele};
  endfunction

  function automatic logic [43:0] dut_vec();
    return {year, month, day, doy, dim, is_leap, month_wrap, year_wrap, load_err};
  endfunction

  task automatic m_tick();
    emw = 0; eyw = 0; ele = 0;
    if (md < m_dim(mm, my)) md++;
    else begin
      md = 1; emw = 1;
      if (mm < 12) mm++;
      else begin mm = 1; my = (my + 1) % 4096; eyw = 1; end
    end
  endtask

  task automatic m_load(input int y, input int m, input int d);
    emw = 0; eyw = 0; ele = 0;
    if (m >= 1 && m <= 12 && d >= 1 && d <= m_dim(m, y)) begin
      my = y; mm = m; md = d;
    end else ele = 1;
  endtask

  task automatic m_reset();
    my = 2023; mm = 1; md = 1; emw = 0; eyw = 0; ele = 0;
  endtask

  task automatic cyc(input bit tk, input bit lv, input int ly, input int lm, input int ld);
    tick = tk; load_valid = lv;
    load_year = 12'(ly); load_month = 4'(lm); load_day = 5'(ld);
    @(posedge clk); #1;
    tick = 0; load_valid = 0;
    if (lv) m_load(ly, lm, ld);
    else if (tk) m_tick();
    else begin emw = 0; eyw = 0; ele = 0; end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1; m_reset();
    if (dut_vec() !== 44'({12'd2023, 4'd1, 5'd1, 9'd1, 5'd31, 1'b0, 3'b000})) begin
      n_fail++; $display("FAIL reset got %h exp %h", dut_vec(),
                         {12'd2023, 4'd1, 5'd1, 9'd1, 5'd31, 1'b0, 3'b000});
    end
    n_chk++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got %h exp %h", dut_vec(), exp_vec());
    end
    n_chk++;
    rst_n = 1;
  endtask

  task automatic test_leap_day();
    cyc(0, 1, 2024, 2, 28);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL load_0228 got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    for (int i = 0; i < 3; i++) begin
      cyc(i < 2, 0, 0, 0, 0);
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL leap_tick%0d got %h exp %h", i, dut_vec(), exp_vec()); end
      n_chk++;
    end
    if ({month, day, doy} !== {4'd3, 5'd1, 9'd61}) begin
      n_fail++; $display("FAIL mar1_doy got %0d/%0d doy %0d exp 3/1 doy 61", month, day, doy);
    end
    n_chk++;
  endtask

  task automatic test_leap_modes();
    cyc(0, 1, 2024, 3, 1);
    if ({y1, m1, d1, doy1, dim1, lp1, mw1, yw1, le1} !== {12'd2024, 4'd3, 5'd1, 9'd61, 5'd31, 1'b1, 3'b000}) begin
      n_fail++; $display("FAIL mode1_mar got %h", {y1, m1, d1, doy1, dim1, lp1});
    end
    n_chk++;
    if ({y0, m0, d0, doy0, dim0, lp0, mw0, yw0, le0} !== {12'd2024, 4'd3, 5'd1, 9'd60, 5'd31, 1'b0, 3'b000}) begin
      n_fail++; $display("FAIL mode0_mar got %h", {y0, m0, d0, doy0, dim0, lp0});
    end
    n_chk++;
    cyc(0, 1, 2100, 2, 29);
    if (dut_vec() !== exp_vec() || load_err !== 1'b1) begin
      n_fail++; $display("FAIL g_2100 got %h exp %h", dut_vec(), exp_vec());
    end
    n_chk++;
    if ({y1, m1, d1, doy1, lp1, le1} !== {12'd2100, 4'd2, 5'd29, 9'd60, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mode1_2100 got %h", {y1, m1, d1, doy1, lp1, le1});
    end
    n_chk++;
    cyc(0, 1, 2000, 2, 29);
    if (dut_vec() !== exp_vec() || load_err !== 1'b0) begin
      n_fail++; $display("FAIL g_2000 got %h exp %h", dut_vec(), exp_vec());
    end
    n_chk++;
    cyc(0, 1, 2024, 2, 29);
    if ({y0, m0, d0, doy0, mw0, yw0, le0} !== {12'd2024, 4'd3, 5'd1, 9'd60, 3'b001}) begin
      n_fail++; $display("FAIL mode0_2024 got %h", {y0, m0, d0, doy0, mw0, yw0, le0});
    end
    n_chk++;
  endtask

  task automatic test_year_wrap();
    cyc(0, 1, 2023, 12, 31);
    if (dut_vec() !== exp_vec() || doy !== 9'd365) begin n_fail++; $display("FAIL dec31 got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    cyc(1, 0, 0, 0, 0);
    if (dut_vec() !== exp_vec() || {month_wrap, year_wrap} !== 2'b11) begin
      n_fail++; $display("FAIL ywrap got %h exp %h", dut_vec(), exp_vec());
    end
    n_chk++;
    cyc(0, 0, 0, 0, 0);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL ywrap_clear got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
  endtask

  task automatic test_boundaries();
    cyc(0, 1, 4095, 12, 31);
    cyc(1, 0, 0, 0, 0);
    if (dut_vec() !== exp_vec() || year !== 12'd0) begin n_fail++; $display("FAIL y4095 got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    cyc(0, 1, 2030, 13, 5);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL month13 got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    cyc(0, 1, 2030, 5, 0);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL day0 got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    cyc(0, 1, 2030, 0, 5);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL month0 got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    cyc(0, 1, 2030, 4, 31);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL apr31 got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    cyc(0, 0, 0, 0, 0);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL err_clear got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
  endtask

  task automatic test_priority();
    cyc(1, 1, 2031, 6, 30);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL load_tick got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    cyc(1, 1, 2031, 6, 31);
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL badload_tick got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
    rst_n = 0;
    cyc(1, 1, 2040, 7, 7);
    rst_n = 1;
    m_reset();
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL rst_load got %h exp %h", dut_vec(), exp_vec()); end
    n_chk++;
  endtask

  task automatic test_random_stream();
    int y, m, d, days;
    y = $urandom_range(1995, 2105);
    m = $urandom_range(1, 12);
    d = $urandom_range(1, m_dim(m, y));
    cyc(0, 1, y, m, d);
    days = 0;
    while (days < 800) begin
      bit tk;
      tk = ($urandom_range(0, 3) != 0);
      cyc(tk, 0, 0, 0, 0);
      if (tk) days++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stream day%0d got %h exp %h", days, dut_vec(), exp_vec());
      end
      n_chk++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_leap_day();
    test_leap_modes();
    test_year_wrap();
    test_boundaries();
    test_priority();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
